// File: rtl/ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion_engine
// Brief    : Tick-driven ball kinematics, wall/paddle bounce and scoring.
// Revision : 1.0 - initial release
// ============================================================================
module ball_motion_engine #(
    parameter int SCREEN_W    = 240,
    parameter int SCREEN_H    = 320,
    parameter int BALL_SIZE   = 4,
    parameter int PADDLE_W    = 40,
    parameter int PADDLE_H    = 4,
    parameter int STEP        = 1,
    parameter int SERVE_TICKS = 2,
    parameter int COORD_WIDTH = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   refreshRate,
    input  logic                   serve,
    input  logic                   pause,
    input  logic [COORD_WIDTH-1:0] paddle1X,
    input  logic [COORD_WIDTH-1:0] paddle2X,
    output logic [COORD_WIDTH-1:0] ballX,
    output logic [COORD_WIDTH-1:0] ballY,
    output logic                   gameActive,
    output logic                   paddleHit,
    output logic                   pointP1,
    output logic                   pointP2
);

    // One guard bit above the coordinate width keeps every sum/compare wrap-free.
    localparam int c_cw    = COORD_WIDTH + 1;
    localparam int c_cnt_w = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

    localparam logic [COORD_WIDTH:0] c_cx   = c_cw'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_WIDTH:0] c_cy   = c_cw'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [COORD_WIDTH:0] c_xmax = c_cw'(SCREEN_W - BALL_SIZE);
    localparam logic [COORD_WIDTH:0] c_ybot = c_cw'(SCREEN_H - PADDLE_H - BALL_SIZE);
    localparam logic [COORD_WIDTH:0] c_ytop = c_cw'(PADDLE_H);
    localparam logic [COORD_WIDTH:0] c_step = c_cw'(STEP);
    localparam logic [COORD_WIDTH:0] c_ball = c_cw'(BALL_SIZE);
    localparam logic [COORD_WIDTH:0] c_pw   = c_cw'(PADDLE_W);
    localparam logic [COORD_WIDTH:0] c_pmax = c_cw'(SCREEN_W - PADDLE_W);
    localparam logic [c_cnt_w-1:0]   c_serve_ticks = c_cnt_w'(SERVE_TICKS);
    localparam logic [c_cnt_w-1:0]   c_cnt_one     = c_cnt_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_serve = 2'd1;
    localparam logic [1:0] c_play  = 2'd2;
    localparam logic [1:0] c_point = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [COORD_WIDTH:0]   ball_x_q, ball_x_d;
    logic [COORD_WIDTH:0]   ball_y_q, ball_y_d;
    logic                   dir_x_q, dir_x_d;   // 1 = moving right
    logic                   dir_y_q, dir_y_d;   // 1 = moving down
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic                   refresh_dly_q, refresh_dly_d;
    logic                   paddle_hit_q, paddle_hit_d;
    logic                   point_p1_q, point_p1_d;
    logic                   point_p2_q, point_p2_d;

    logic                   w_tick;
    logic                   w_step_en;
    logic [COORD_WIDTH:0]   w_p1;
    logic [COORD_WIDTH:0]   w_p2;
    logic [COORD_WIDTH:0]   w_nx;
    logic [c_cnt_w-1:0]     w_cnt_inc;

    assign w_tick    = refreshRate & ~refresh_dly_q;
    assign w_step_en = w_tick & ~pause;
    assign w_cnt_inc = cnt_q + c_cnt_one;
    assign w_p1      = ({1'b0, paddle1X} > c_pmax) ? c_pmax : {1'b0, paddle1X};
    assign w_p2      = ({1'b0, paddle2X} > c_pmax) ? c_pmax : {1'b0, paddle2X};

    always_comb begin
        refresh_dly_d = refreshRate;
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        cnt_d         = cnt_q;
        paddle_hit_d  = 1'b0;
        point_p1_d    = 1'b0;
        point_p2_d    = 1'b0;
        w_nx          = ball_x_q;

        case (state_q)
            c_idle: begin
                ball_x_d = c_cx;
                ball_y_d = c_cy;
                if (serve) begin
                    state_d = c_serve;
                    cnt_d   = '0;
                end
            end
            c_serve: begin
                ball_x_d = c_cx;
                ball_y_d = c_cy;
                if (w_step_en) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_serve_ticks) begin
                        state_d = c_play;
                    end
                end
            end
            c_play: begin
                if (w_step_en) begin
                    if (dir_x_q) begin
                        if (ball_x_q + c_step >= c_xmax) begin
                            w_nx    = c_xmax;
                            dir_x_d = 1'b0;
                        end else begin
                            w_nx = ball_x_q + c_step;
                        end
                    end else if (ball_x_q <= c_step) begin
                        w_nx    = '0;
                        dir_x_d = 1'b1;
                    end else begin
                        w_nx = ball_x_q - c_step;
                    end
                    ball_x_d = w_nx;

                    // The paddle test uses this tick's new X so corner bounces resolve together.
                    if (dir_y_q) begin
                        if (ball_y_q + c_step >= c_ybot) begin
                            ball_y_d = c_ybot;
                            if ((w_nx + c_ball > w_p1) && (w_nx < w_p1 + c_pw)) begin
                                dir_y_d      = 1'b0;
                                paddle_hit_d = 1'b1;
                            end else begin
                                point_p2_d = 1'b1;
                                state_d    = c_point;
                            end
                        end else begin
                            ball_y_d = ball_y_q + c_step;
                        end
                    end else begin
                        if (ball_y_q <= c_ytop + c_step) begin
                            ball_y_d = c_ytop;
                            if ((w_nx + c_ball > w_p2) && (w_nx < w_p2 + c_pw)) begin
                                dir_y_d      = 1'b1;
                                paddle_hit_d = 1'b1;
                            end else begin
                                point_p1_d = 1'b1;
                                state_d    = c_point;
                            end
                        end else begin
                            ball_y_d = ball_y_q - c_step;
                        end
                    end
                end
            end
            default: begin
                // Re-serve toward whoever conceded: a bottom miss sends the ball down.
                ball_x_d = c_cx;
                ball_y_d = c_cy;
                dir_y_d  = point_p2_q;
                cnt_d    = '0;
                state_d  = c_serve;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= c_idle;
            ball_x_q      <= c_cx;
            ball_y_q      <= c_cy;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            cnt_q         <= '0;
            refresh_dly_q <= 1'b0;
            paddle_hit_q  <= 1'b0;
            point_p1_q    <= 1'b0;
            point_p2_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            cnt_q         <= cnt_d;
            refresh_dly_q <= refresh_dly_d;
            paddle_hit_q  <= paddle_hit_d;
            point_p1_q    <= point_p1_d;
            point_p2_q    <= point_p2_d;
        end
    end

    assign ballX      = ball_x_q[COORD_WIDTH-1:0];
    assign ballY      = ball_y_q[COORD_WIDTH-1:0];
    assign gameActive = (state_q != c_idle);
    assign paddleHit  = paddle_hit_q;
    assign pointP1    = point_p1_q;
    assign pointP2    = point_p2_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion_engine
// Brief    : Directed self-checking bench for ball_motion_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_motion_engine;

    logic       clock;
    logic       reset;
    logic       refreshRate;
    logic       serve;
    logic       pause;
    logic [8:0] paddle1X;
    logic [8:0] paddle2X;
    logic [8:0] ballX;
    logic [8:0] ballY;
    logic       gameActive;
    logic       paddleHit;
    logic       pointP1;
    logic       pointP2;

    int n_tests = 0;
    int n_fail  = 0;

    ball_motion_engine dut (
        .clock      (clock),
        .reset      (reset),
        .refreshRate(refreshRate),
        .serve      (serve),
        .pause      (pause),
        .paddle1X   (paddle1X),
        .paddle2X   (paddle2X),
        .ballX      (ballX),
        .ballY      (ballY),
        .gameActive (gameActive),
        .paddleHit  (paddleHit),
        .pointP1    (pointP1),
        .pointP2    (pointP2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One low cycle then one high cycle; returns on the negedge right after the update edge.
    task automatic do_tick();
        refreshRate = 1'b0;
        @(negedge clock);
        refreshRate = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic apply_reset();
        reset = 1'b0; serve = 1'b0; pause = 1'b0; refreshRate = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic start_game();
        serve = 1'b1;
        @(negedge clock);
        serve = 1'b0;
        do_ticks(2);
    endtask

    task automatic test_reset();
        reset = 1'b0; serve = 1'b0; pause = 1'b0; refreshRate = 1'b0;
        paddle1X = 9'd0; paddle2X = 9'd0;
        @(negedge clock);
        @(negedge clock);
        n_tests++; if (ballX !== 9'd118) begin n_fail++; $display("FAIL reset_x: got %0d exp 118", ballX); end
        n_tests++; if (ballY !== 9'd158) begin n_fail++; $display("FAIL reset_y: got %0d exp 158", ballY); end
        n_tests++; if (gameActive !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b exp 0", gameActive); end
        n_tests++; if ({paddleHit, pointP1, pointP2} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b exp 000", {paddleHit, pointP1, pointP2}); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_idle_hold();
        logic any_pulse;
        any_pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            any_pulse = any_pulse | paddleHit | pointP1 | pointP2 | gameActive;
        end
        n_tests++; if (ballX !== 9'd118) begin n_fail++; $display("FAIL idle_x: got %0d exp 118", ballX); end
        n_tests++; if (ballY !== 9'd158) begin n_fail++; $display("FAIL idle_y: got %0d exp 158", ballY); end
        n_tests++; if (any_pulse !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got %b exp 0", any_pulse); end
    endtask

    task automatic test_serve_latency();
        serve = 1'b1;
        @(negedge clock);
        serve = 1'b0;
        n_tests++; if (gameActive !== 1'b1) begin n_fail++; $display("FAIL serve_active: got %b exp 1", gameActive); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd118, 9'd158}) begin n_fail++; $display("FAIL serve_t1: got %0d,%0d exp 118,158", ballX, ballY); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd118, 9'd158}) begin n_fail++; $display("FAIL serve_t2: got %0d,%0d exp 118,158", ballX, ballY); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd119, 9'd159}) begin n_fail++; $display("FAIL serve_t3: got %0d,%0d exp 119,159", ballX, ballY); end
    endtask

    task automatic test_wall_bounce();
        apply_reset();
        paddle1X = 9'd0; paddle2X = 9'd0;
        start_game();
        do_ticks(118);
        n_tests++; if ({ballX, ballY} !== {9'd236, 9'd276}) begin n_fail++; $display("FAIL wall_t118: got %0d,%0d exp 236,276", ballX, ballY); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd235, 9'd277}) begin n_fail++; $display("FAIL wall_t119: got %0d,%0d exp 235,277", ballX, ballY); end
    endtask

    task automatic test_paddle_bounce();
        apply_reset();
        paddle1X = 9'd180; paddle2X = 9'd100;
        start_game();
        do_ticks(153);
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd200, 9'd312}) begin n_fail++; $display("FAIL hit_pos: got %0d,%0d exp 200,312", ballX, ballY); end
        n_tests++; if ({paddleHit, pointP2} !== 2'b10) begin n_fail++; $display("FAIL hit_pulse: got hit=%b p2=%b exp hit=1 p2=0", paddleHit, pointP2); end
        @(negedge clock);
        n_tests++; if (paddleHit !== 1'b0) begin n_fail++; $display("FAIL hit_one_cycle: got %b exp 0", paddleHit); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd199, 9'd311}) begin n_fail++; $display("FAIL hit_t155: got %0d,%0d exp 199,311", ballX, ballY); end
        do_ticks(306);
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd108, 9'd4}) begin n_fail++; $display("FAIL top_hit_pos: got %0d,%0d exp 108,4", ballX, ballY); end
        n_tests++; if ({paddleHit, pointP1} !== 2'b10) begin n_fail++; $display("FAIL top_hit_pulse: got hit=%b p1=%b exp hit=1 p1=0", paddleHit, pointP1); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd109, 9'd5}) begin n_fail++; $display("FAIL top_after: got %0d,%0d exp 109,5", ballX, ballY); end
    endtask

    task automatic test_paddle_clamp();
        apply_reset();
        paddle1X = 9'd300; paddle2X = 9'd0;
        start_game();
        do_ticks(154);
        n_tests++; if ({paddleHit, pointP2} !== 2'b10) begin n_fail++; $display("FAIL clamp_hit: got hit=%b p2=%b exp hit=1 p2=0", paddleHit, pointP2); end
    endtask

    task automatic test_miss_bottom();
        apply_reset();
        paddle1X = 9'd0; paddle2X = 9'd0;
        start_game();
        do_ticks(154);
        n_tests++; if ({pointP2, pointP1, paddleHit} !== 3'b100) begin n_fail++; $display("FAIL miss_bot_pulse: got p2,p1,hit=%b exp 100", {pointP2, pointP1, paddleHit}); end
        n_tests++; if (ballY !== 9'd312) begin n_fail++; $display("FAIL miss_bot_y: got %0d exp 312", ballY); end
        @(negedge clock);
        n_tests++; if ({ballX, ballY} !== {9'd118, 9'd158}) begin n_fail++; $display("FAIL miss_bot_centre: got %0d,%0d exp 118,158", ballX, ballY); end
        n_tests++; if ({pointP2, gameActive} !== 2'b01) begin n_fail++; $display("FAIL miss_bot_after: got p2=%b act=%b exp p2=0 act=1", pointP2, gameActive); end
        do_ticks(2);
        n_tests++; if ({ballX, ballY} !== {9'd118, 9'd158}) begin n_fail++; $display("FAIL miss_bot_hold: got %0d,%0d exp 118,158", ballX, ballY); end
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd117, 9'd159}) begin n_fail++; $display("FAIL miss_bot_resume: got %0d,%0d exp 117,159", ballX, ballY); end
    endtask

    task automatic test_miss_top();
        apply_reset();
        paddle1X = 9'd180; paddle2X = 9'd0;
        start_game();
        do_ticks(462);
        n_tests++; if ({pointP1, pointP2, paddleHit} !== 3'b100) begin n_fail++; $display("FAIL miss_top_pulse: got p1,p2,hit=%b exp 100", {pointP1, pointP2, paddleHit}); end
        @(negedge clock);
        n_tests++; if ({ballX, ballY, pointP1} !== {9'd118, 9'd158, 1'b0}) begin n_fail++; $display("FAIL miss_top_centre: got %0d,%0d p1=%b exp 118,158 p1=0", ballX, ballY, pointP1); end
        do_ticks(3);
        n_tests++; if ({ballX, ballY} !== {9'd119, 9'd157}) begin n_fail++; $display("FAIL miss_top_resume: got %0d,%0d exp 119,157", ballX, ballY); end
    endtask

    task automatic test_pause_reset();
        apply_reset();
        paddle1X = 9'd180; paddle2X = 9'd0;
        start_game();
        do_ticks(10);
        n_tests++; if ({ballX, ballY} !== {9'd128, 9'd168}) begin n_fail++; $display("FAIL pause_pre: got %0d,%0d exp 128,168", ballX, ballY); end
        pause = 1'b1;
        do_ticks(20);
        n_tests++; if ({ballX, ballY} !== {9'd128, 9'd168}) begin n_fail++; $display("FAIL pause_frozen: got %0d,%0d exp 128,168", ballX, ballY); end
        pause = 1'b0;
        do_tick();
        n_tests++; if ({ballX, ballY} !== {9'd129, 9'd169}) begin n_fail++; $display("FAIL pause_resume: got %0d,%0d exp 129,169", ballX, ballY); end
        do_ticks(143);
        n_tests++; if (paddleHit !== 1'b1) begin n_fail++; $display("FAIL async_pre_hit: got %b exp 1", paddleHit); end
        #1 reset = 1'b0;
        #1;
        n_tests++; if ({ballX, ballY} !== {9'd118, 9'd158}) begin n_fail++; $display("FAIL async_pos: got %0d,%0d exp 118,158", ballX, ballY); end
        n_tests++; if ({gameActive, paddleHit, pointP1, pointP2} !== 4'b0000) begin n_fail++; $display("FAIL async_flags: got %b exp 0000", {gameActive, paddleHit, pointP1, pointP2}); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_serve_latency();
        test_wall_bounce();
        test_paddle_bounce();
        test_paddle_clamp();
        test_miss_bottom();
        test_miss_top();
        test_pause_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Tick-driven ball kinematics and collision engine for the two-player ping-pong game.
- Sits directly downstream of the refresh-rate generator. It consumes that generator's square-wave `refreshRate` output and advances the ball one step per rising edge.
- It bounces the ball off the side walls and paddles, and emits point and hit events to the score/display logic.
- Playfield is portrait: player 1's paddle is on the bottom row, player 2's paddle is on the top row.

Parameters:
- SCREEN_W, 240, playfield width in pixels.
- SCREEN_H, 320, playfield height in pixels.
- BALL_SIZE, 4, ball edge length (square ball).
- PADDLE_W, 40, paddle width.
- PADDLE_H, 4, paddle height. Paddles occupy y rows [0, PADDLE_H) and [SCREEN_H-PADDLE_H, SCREEN_H).
- STEP, 1, pixels moved per axis per tick.
- SERVE_TICKS, 2, ticks the ball is held at centre before play resumes.
- COORD_WIDTH, 9, width of all coordinate buses.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-low reset (0 = reset).
- refreshRate  input  1  square wave from the refresh generator. Each rising edge is one game tick.
- serve  input  1  single-cycle request to start the game. Honoured only in IDLE.
- pause  input  1  level input. While high, ticks are ignored in SERVE and PLAY.
- paddle1X  input  COORD_WIDTH  left x of the bottom paddle.
- paddle2X  input  COORD_WIDTH  left x of the top paddle.
- ballX  output  COORD_WIDTH  ball left x.
- ballY  output  COORD_WIDTH  ball top y.
- gameActive  output  1  high in SERVE, PLAY and POINT.
- paddleHit  output  1  one-cycle pulse on any paddle bounce.
- pointP1  output  1  one-cycle pulse when player 1 scores (top paddle missed).
- pointP2  output  1  one-cycle pulse when player 2 scores (bottom paddle missed).

Behaviour:
- Definitions:
  - CX = (SCREEN_W-BALL_SIZE)/2, CY = (SCREEN_H-BALL_SIZE)/2.
  - XMAX = SCREEN_W-BALL_SIZE.
  - YBOT = SCREEN_H-PADDLE_H-BALL_SIZE, YTOP = PADDLE_H.
- Reset (asynchronous, while reset=0):
  - ballX=CX, ballY=CY, dirX=+, dirY=+ (down).
  - State IDLE, serve counter 0, edge-detect register 0.
  - All pulse outputs 0; gameActive 0.
- Tick detection:
  - tick = refreshRate & ~refreshRate_d, where refreshRate_d is refreshRate registered on clock.
  - tick is high for exactly one cycle, one cycle after the rising edge. All state updates occur on the tick cycle.
  - Falling edges do nothing.
- Paddle input clamp: paddle inputs greater than SCREEN_W-PADDLE_W are clamped to SCREEN_W-PADDLE_W internally.
- FSM states:
  - IDLE: ball held at centre. serve=1 moves to SERVE and clears the serve counter. serve is ignored in every other state.
  - SERVE: ball held at centre. Each unpaused tick increments the counter. The tick that makes the counter equal SERVE_TICKS enters PLAY; the ball does not move on that tick.
  - PLAY: each unpaused tick updates X then Y, using the updated X for the paddle overlap test.
    - X, moving +: if ballX+STEP >= XMAX then ballX=XMAX and dirX becomes -. Otherwise ballX += STEP.
    - X, moving -: if ballX <= STEP then ballX=0 and dirX becomes +. Otherwise ballX -= STEP.
    - Y, moving down: if ballY+STEP >= YBOT then ballY=YBOT and the bottom paddle is tested. Otherwise ballY += STEP.
    - Y, moving up: if ballY <= YTOP+STEP then ballY=YTOP and the top paddle is tested. Otherwise ballY -= STEP.
    - Overlap test: new ballX+BALL_SIZE > pX AND new ballX < pX+PADDLE_W.
    - Hit: dirY flips, paddleHit pulses on the cycle after the tick, state remains PLAY.
    - Miss: the opposite player's point pulse fires on the cycle after the tick, and the FSM goes to POINT.
  - POINT (one cycle):
    - ballX=CX, ballY=CY.
    - dirY points toward the player who conceded (bottom miss → down, top miss → up). dirX is unchanged.
    - Counter cleared; next state SERVE.
- Simultaneous events:
  - A side-wall bounce and a paddle bounce on the same tick are both applied.
  - pause=1 on a tick cycle suppresses that tick.
- Width rule: all arithmetic is unsigned at COORD_WIDTH+1 bits, so no intermediate wraps.
- Reset mid-game: returns to the reset state immediately, and pulse outputs drop to 0 asynchronously.

Test Plan (defaults):
- Idle hold: release reset, refreshRate toggling, no serve for 10 ticks → ballX=118, ballY=158, gameActive=0, no pulses.
- Serve latency: serve pulse → gameActive=1 next cycle. Ticks 1-2 leave the ball at 118,158; tick 3 gives 119,159.
- Wall bounce: paddles at 0, serve, play 118 ticks → ballX=236 and dirX flips. Tick 119 → ballX=235, ballY=277.
- Paddle hit: paddle1X=180. At play tick 154 → ballY=312, ballX=200, paddleHit one cycle. Tick 155 → ballY=311.
- Miss/score: paddle1X=0 → at play tick 154, pointP2 pulses one cycle, ball returns to 118,158 in SERVE heading down. Movement resumes 3 ticks later.
- Pause/reset: pause=1 for 20 ticks mid-PLAY → position frozen. Then assert reset=0 mid-PLAY → outputs at reset values without waiting for a clock edge.
